// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake movement-step scheduler.
package snake_pkg;

   // Width of the tick period and tick counter.
   localparam int TICK_W = 24;

   // The direction queue holds exactly two pending presses.
   localparam int QDEPTH = 2;

   typedef enum logic [1:0] {
      UP    = 2'b00,
      DOWN  = 2'b01,
      LEFT  = 2'b10,
      RIGHT = 2'b11
   } direction_e;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WAIT_TICK = 2'b01,
      REQ       = 2'b10,
      GAME_OVER = 2'b11
   } state_e;

   // Opposite heading: UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
   function automatic logic [1:0] opposite(input logic [1:0] d);
      return d ^ 2'b01;
   endfunction

endpackage

// File: rtl/snake_step_scheduler_dir_queue.sv
// Two-entry direction FIFO. The owner decides legality; this block only
// stores, and tolerates a pop and a push in the same cycle even when full.
module dir_queue
   import snake_pkg::*;
(
   input  logic       clk,
   input  logic       nrst,
   input  logic       clear,
   input  logic       push,
   input  logic [1:0] push_data,
   input  logic       pop,
   output logic [1:0] head,
   output logic [1:0] tail,
   output logic [1:0] count
);

   logic [1:0] mem_q [QDEPTH];
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic [1:0] count_d;
   logic       do_pop;
   logic       do_push;
   logic       wr_ptr;

   // A pop on an empty queue does nothing; a push is allowed when full only
   // if a pop frees the head slot in the same cycle.
   assign do_pop  = pop && (count_q != 2'd0);
   assign do_push = push && (do_pop || (count_q != 2'd2));

   // Next free slot; with two entries it is the head slot, which a
   // simultaneous pop is vacating.
   assign wr_ptr = rd_ptr_q ^ count_q[0];

   assign head  = mem_q[rd_ptr_q];
   assign tail  = mem_q[rd_ptr_q ^ count_q[1]];
   assign count = count_q;

   // Occupancy update from the accepted push/pop pair.
   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Storage, read pointer and occupancy.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         for (int i = 0; i < QDEPTH; i++) begin
            mem_q[i] <= 2'b00;
         end
      end else if (clear) begin
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr] <= push_data;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/snake_step_scheduler.sv
// Snake movement sequencer: filters direction presses into a small queue,
// runs the game-tick timer and issues one move per tick over req/ack.
module snake_step_scheduler
   import snake_pkg::*;
#(
   parameter logic [TICK_W-1:0] TICK_PERIOD = 24'd1_000_000,
   parameter logic [TICK_W-1:0] TICK_MIN    = 24'd250_000,
   parameter logic [TICK_W-1:0] SPEEDUP     = 24'd50_000
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       enable,
   input  logic       pause,
   input  logic       dir_valid,
   input  logic [1:0] dir_in,
   input  logic       apple_eaten,
   input  logic       step_ack,
   input  logic       collision,
   output logic       step_req,
   output logic [1:0] step_dir,
   output logic [1:0] cur_dir,
   output logic [1:0] q_count,
   output logic       game_over
);

   state_e            state_q;
   logic [1:0]        cur_dir_q;
   logic [1:0]        step_dir_q;
   logic              step_req_q;
   logic              game_over_q;
   logic [TICK_W-1:0] period_q;
   logic [TICK_W-1:0] cnt_q;

   logic [1:0]        q_head;
   logic [1:0]        q_tail;
   logic [1:0]        q_cnt;
   logic              q_pop;
   logic              q_push;
   logic              q_clear;

   logic              tick_fire;
   logic [1:0]        ref_dir;
   logic              press_legal;
   logic              full_after_pop;
   logic [1:0]        cur_dir_d;
   logic [TICK_W-1:0] period_d;
   logic [TICK_W-1:0] period_margin;

   // Tick expiry, queue control and press legality.
   always_comb begin
      tick_fire = (state_q == WAIT_TICK) && !pause && (cnt_q == '0);
      q_clear   = !enable;
      q_pop     = enable && tick_fire && (q_cnt != 2'd0);
      cur_dir_d = q_pop ? q_head : cur_dir_q;

      // Compare against the newest pending heading. After a same-cycle pop
      // this is still the old tail when one remains, otherwise the popped
      // head, which equals the old tail, so the pre-pop tail is correct.
      ref_dir        = (q_cnt != 2'd0) ? q_tail : cur_dir_q;
      press_legal    = (dir_in != ref_dir) && (dir_in != opposite(ref_dir));
      full_after_pop = (q_cnt == 2'd2) && !q_pop;
      q_push         = enable && dir_valid && (state_q != GAME_OVER) &&
                       press_legal && !full_after_pop;

      // Saturating speed-up; period never drops below TICK_MIN.
      period_margin = period_q - TICK_MIN;
      period_d      = (period_margin > SPEEDUP) ? (period_q - SPEEDUP) : TICK_MIN;
   end

   dir_queue u_dir_queue (
      .clk       (clk),
      .nrst      (nrst),
      .clear     (q_clear),
      .push      (q_push),
      .push_data (dir_in),
      .pop       (q_pop),
      .head      (q_head),
      .tail      (q_tail),
      .count     (q_cnt)
   );

   // Game FSM with tick counter, heading, period and registered handshake outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         cur_dir_q   <= RIGHT;
         step_dir_q  <= RIGHT;
         step_req_q  <= 1'b0;
         game_over_q <= 1'b0;
         period_q    <= TICK_PERIOD;
         cnt_q       <= TICK_PERIOD - 1'b1;
      end else if (!enable) begin
         state_q     <= IDLE;
         cur_dir_q   <= RIGHT;
         step_dir_q  <= RIGHT;
         step_req_q  <= 1'b0;
         game_over_q <= 1'b0;
         period_q    <= TICK_PERIOD;
         cnt_q       <= TICK_PERIOD - 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= WAIT_TICK;
               cnt_q   <= period_q - 1'b1;
            end
            WAIT_TICK: begin
               if (tick_fire) begin
                  state_q    <= REQ;
                  cur_dir_q  <= cur_dir_d;
                  step_dir_q <= cur_dir_d;
                  step_req_q <= 1'b1;
               end else if (!pause) begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            REQ: begin
               if (step_ack) begin
                  step_req_q <= 1'b0;
                  if (collision) begin
                     state_q     <= GAME_OVER;
                     game_over_q <= 1'b1;
                  end else begin
                     state_q <= WAIT_TICK;
                     cnt_q   <= period_q - 1'b1;
                  end
               end
            end
            default: begin
               // GAME_OVER: hold until enable drops.
               state_q <= GAME_OVER;
            end
         endcase

         // A new period only matters at the next reload of the counter.
         if (apple_eaten && (state_q != IDLE)) begin
            period_q <= period_d;
         end
      end
   end

   assign step_req  = step_req_q;
   assign step_dir  = step_dir_q;
   assign cur_dir   = cur_dir_q;
   assign q_count   = q_cnt;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Randomized bench for snake_step_scheduler against a behavioural game model.
module tb_snake_step_scheduler;

   localparam int P0   = 10;
   localparam int PMIN = 4;
   localparam int SP   = 2;
   localparam int NCYC = 4000;

   localparam int M_IDLE = 0;
   localparam int M_WAIT = 1;
   localparam int M_REQ  = 2;
   localparam int M_OVER = 3;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       enable = 1'b0;
   logic       pause = 1'b0;
   logic       dir_valid = 1'b0;
   logic [1:0] dir_in = 2'b00;
   logic       apple_eaten = 1'b0;
   logic       step_ack = 1'b0;
   logic       collision = 1'b0;
   logic       step_req;
   logic [1:0] step_dir;
   logic [1:0] cur_dir;
   logic [1:0] q_count;
   logic       game_over;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the game sequencer.
   int         m_mode;
   logic [1:0] m_dir;
   logic [1:0] m_sdir;
   bit         m_req;
   bit         m_over;
   int         m_period;
   int         m_cnt;
   logic [1:0] m_q[$];
   int         m_steps = 0;

   always #5 clk = ~clk;

   snake_step_scheduler #(
      .TICK_PERIOD (24'd10),
      .TICK_MIN    (24'd4),
      .SPEEDUP     (24'd2)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .enable      (enable),
      .pause       (pause),
      .dir_valid   (dir_valid),
      .dir_in      (dir_in),
      .apple_eaten (apple_eaten),
      .step_ack    (step_ack),
      .collision   (collision),
      .step_req    (step_req),
      .step_dir    (step_dir),
      .cur_dir     (cur_dir),
      .q_count     (q_count),
      .game_over   (game_over)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode   = M_IDLE;
      m_dir    = 2'b11;
      m_sdir   = 2'b11;
      m_req    = 1'b0;
      m_over   = 1'b0;
      m_period = P0;
      m_cnt    = P0 - 1;
      m_q.delete();
   endtask

   // One clock of game rules, using the inputs present at this edge.
   task automatic model_step();
      int         old_mode;
      logic [1:0] rf;
      if (!enable) begin
         model_reset();
         return;
      end
      old_mode = m_mode;
      case (old_mode)
         M_IDLE: begin
            m_mode = M_WAIT;
            m_cnt  = m_period - 1;
         end
         M_WAIT: begin
            if (!pause) begin
               if (m_cnt == 0) begin
                  m_mode = M_REQ;
                  m_req  = 1'b1;
                  if (m_q.size() > 0) m_dir = m_q.pop_front();
                  m_sdir = m_dir;
               end else begin
                  m_cnt--;
               end
            end
         end
         M_REQ: begin
            if (step_ack) begin
               m_req = 1'b0;
               m_steps++;
               $display("step %0d: dir=%0d collision=%0d period=%0d queued=%0d",
                        m_steps, m_sdir, collision, m_period, m_q.size());
               if (collision) begin
                  m_mode = M_OVER;
                  m_over = 1'b1;
               end else begin
                  m_mode = M_WAIT;
                  m_cnt  = m_period - 1;
               end
            end
         end
         default: ;
      endcase
      // Presses are judged against the newest heading after any pop above.
      if (dir_valid && old_mode != M_OVER) begin
         rf = (m_q.size() > 0) ? m_q[$] : m_dir;
         if (dir_in != rf && dir_in != (rf ^ 2'b01) && m_q.size() < 2)
            m_q.push_back(dir_in);
      end
      if (apple_eaten && old_mode != M_IDLE) begin
         m_period = (m_period - SP < PMIN) ? PMIN : m_period - SP;
      end
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, " step_req"},  32'(step_req),  32'(m_req));
      check_val({tag, " step_dir"},  32'(step_dir),  32'(m_sdir));
      check_val({tag, " cur_dir"},   32'(cur_dir),   32'(m_dir));
      check_val({tag, " q_count"},   32'(q_count),   32'(m_q.size()));
      check_val({tag, " game_over"}, 32'(game_over), 32'(m_over));
   endtask

   task automatic drive_inputs(input int cyc);
      enable      = ($urandom_range(0, 199) != 0) && !(m_over && $urandom_range(0, 9) == 0);
      pause       = ((cyc % 250) >= 100 && (cyc % 250) < 130) || ($urandom_range(0, 19) == 0);
      dir_valid   = ($urandom_range(0, 2) == 0);
      dir_in      = 2'($urandom_range(0, 3));
      apple_eaten = ($urandom_range(0, 24) == 0);
      step_ack    = m_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      collision   = ($urandom_range(0, 29) == 0);
   endtask

   initial begin
      bit arst_pending;
      arst_pending = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      nrst = 1'b1;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         model_step();
         #1;
         check_outputs("run");
         if (cyc % 1000 == 600) arst_pending = 1'b1;
         if (arst_pending && m_req) begin
            // Reset in the middle of a handshake must drop step_req at once.
            arst_pending = 1'b0;
            #2;
            nrst = 1'b0;
            #1;
            model_reset();
            check_outputs("async_rst");
            @(negedge clk);
            nrst = 1'b1;
         end
         drive_inputs(cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
